// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath and the arbiter FSM encoding.
//   WIDTH / OPW : default operand/result and opcode widths
//   OP_*        : opcode values understood by the ALU
//   state_e     : arbiter FSM state encoding
package alu_pkg;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned OPW   = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   valid_i      : request valid per requester
//   last_grant_i : requester served most recently
//   grant_c_o    : index of the winning requester
//   any_c_o      : at least one requester is valid
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_c_o,
    output logic       any_c_o
);

    // On a tie the requester that was not served last wins; otherwise the lone valid one.
    always_comb begin
        any_c_o   = |valid_i;
        grant_c_o = (valid_i == 2'b11) ? ~last_grant_i : valid_i[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : per-requester request handshake (req_ready combinational, IDLE only)
//   req_opcode*/req_op1_*/req_op2_* : request payload per requester
//   rsp_valid/rsp_ready      : per-requester response handshake
//   rsp_data                 : shared result bus
//   alu_opcode/alu_op1/alu_op2 : registered ALU drive, held between operations
//   alu_out                  : combinational ALU result
//   busy                     : FSM not in IDLE
//   grant_id                 : current/last owner
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = alu_pkg::WIDTH,
    parameter int unsigned OPW     = alu_pkg::OPW,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_opcode0,
    input  logic [OPW-1:0]   req_opcode1,
    input  logic [WIDTH-1:0] req_op1_0,
    input  logic [WIDTH-1:0] req_op1_1,
    input  logic [WIDTH-1:0] req_op2_0,
    input  logic [WIDTH-1:0] req_op2_1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             grant_id
);

    localparam int unsigned CNT_W = 4;

    state_e             state_q,      state_d;
    logic               owner_q,      owner_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [OPW-1:0]     opcode_q,     opcode_d;
    logic [WIDTH-1:0]   op1_q,        op1_d;
    logic [WIDTH-1:0]   op2_q,        op2_d;
    logic [WIDTH-1:0]   result_q,     result_d;

    logic               arb_grant;
    logic               arb_any;

    rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_c_o    (arb_grant),
        .any_c_o      (arb_any)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            opcode_q     <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            opcode_q     <= opcode_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            result_q     <= result_d;
        end
    end

    // Next-state logic and the combinational request accept.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        result_d     = result_q;
        req_ready    = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready[arb_grant] = 1'b1;
                    owner_d  = arb_grant;
                    opcode_d = arb_grant ? req_opcode1 : req_opcode0;
                    op1_d    = arb_grant ? req_op1_1   : req_op1_0;
                    op2_d    = arb_grant ? req_op2_1   : req_op2_0;
                    cnt_d    = CNT_W'(ALU_LAT - 1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable for ALU_LAT cycles once cnt reaches zero.
                if (cnt_q == '0) begin
                    result_d = alu_out;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        rsp_valid  = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
        rsp_data   = result_q;
        alu_opcode = opcode_q;
        alu_op1    = op1_q;
        alu_op2    = op2_q;
        busy       = (state_q != IDLE);
        grant_id   = owner_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=4.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // ---------------- instance A: ALU_LAT = 1 ----------------
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_opcode0, req_opcode1, alu_opcode;
    logic [11:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
    logic [11:0] rsp_data, alu_op1, alu_op2, alu_out;
    logic        busy, grant_id;

    assign alu_out = (alu_opcode == 3'b000) ? (alu_op1 + alu_op2) : (alu_op1 & alu_op2);

    alu_arbiter #(.ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
        .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
        .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_out(alu_out), .busy(busy), .grant_id(grant_id)
    );

    // ---------------- instance B: ALU_LAT = 4 ----------------
    logic        rst4;
    logic [1:0]  req_valid4, req_ready4, rsp_valid4, rsp_ready4;
    logic [2:0]  req_opcode0_4, req_opcode1_4, alu_opcode4;
    logic [11:0] req_op1_0_4, req_op1_1_4, req_op2_0_4, req_op2_1_4;
    logic [11:0] rsp_data4, alu_op1_4, alu_op2_4, alu_out4;
    logic        busy4, grant_id4;

    assign alu_out4 = (alu_opcode4 == 3'b000) ? (alu_op1_4 + alu_op2_4) : (alu_op1_4 & alu_op2_4);

    alu_arbiter #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst(rst4),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_opcode0(req_opcode0_4), .req_opcode1(req_opcode1_4),
        .req_op1_0(req_op1_0_4), .req_op1_1(req_op1_1_4),
        .req_op2_0(req_op2_0_4), .req_op2_1(req_op2_1_4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
        .alu_opcode(alu_opcode4), .alu_op1(alu_op1_4), .alu_op2(alu_op2_4),
        .alu_out(alu_out4), .busy(busy4), .grant_id(grant_id4)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;  rst4 = 1'b1;
        req_valid  = 2'b00; rsp_ready  = 2'b00;
        req_valid4 = 2'b00; rsp_ready4 = 2'b00;
        req_opcode0 = '0; req_opcode1 = '0; req_op1_0 = '0; req_op1_1 = '0; req_op2_0 = '0; req_op2_1 = '0;
        req_opcode0_4 = '0; req_opcode1_4 = '0; req_op1_0_4 = '0; req_op1_1_4 = '0;
        req_op2_0_4 = '0; req_op2_1_4 = '0;
        step(); step();

        // Reset values
        check("rst_req_ready", 16'(req_ready), 16'h0);
        check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_rsp_data",  16'(rsp_data),  16'h0);
        check("rst_alu_op1",   16'(alu_op1),   16'h0);
        check("rst_busy",      16'(busy),      16'h0);
        check("rst_grant_id",  16'(grant_id),  16'h0);

        // Single request: 0x381 + 0x342 = 0x6C3
        rst = 1'b0;
        step();
        req_valid = 2'b01; req_opcode0 = 3'b000; req_op1_0 = 12'h381; req_op2_0 = 12'h342;
        rsp_ready = 2'b11;
        #1 check("single_req_ready_c0", 16'(req_ready), 16'h1);
        step();
        req_valid = 2'b00;
        #1;
        check("single_alu_op1_c1", 16'(alu_op1), 16'h381);
        check("single_busy_c1",    16'(busy),    16'h1);
        check("single_rsp_valid_c1", 16'(rsp_valid), 16'h0);
        step();
        check("single_rsp_valid_c2", 16'(rsp_valid), 16'h1);
        check("single_rsp_data_c2",  16'(rsp_data),  16'h6C3);
        step();
        check("single_busy_c3",      16'(busy),      16'h0);
        check("single_rsp_valid_c3", 16'(rsp_valid), 16'h0);
        check("single_alu_op1_hold", 16'(alu_op1),   16'h381);

        // Simultaneous requests after reset: 3+5 then 3&5
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11;
        req_opcode0 = 3'b000; req_op1_0 = 12'd3; req_op2_0 = 12'd5;
        req_opcode1 = 3'b001; req_op1_1 = 12'd3; req_op2_1 = 12'd5;
        #1 check("sim_req_ready_first", 16'(req_ready), 16'h1);
        step();
        req_valid = 2'b10;
        #1 check("sim_rsp_valid_exec0", 16'(rsp_valid), 16'h0);
        step();
        check("sim_rsp_valid_r0", 16'(rsp_valid), 16'h1);
        check("sim_rsp_data_r0",  16'(rsp_data),  16'h008);
        step();
        check("sim_req_ready_second", 16'(req_ready), 16'h2);
        step();
        req_valid = 2'b00;
        #1 check("sim_grant_id_1", 16'(grant_id), 16'h1);
        step();
        check("sim_rsp_valid_r1", 16'(rsp_valid), 16'h2);
        check("sim_rsp_data_r1",  16'(rsp_data),  16'h001);
        step();
        check("sim_busy_done", 16'(busy), 16'h0);

        // Fairness: both hold valid for 6 operations; last owner was 1
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("fair_req_ready_%0d", i), 16'(req_ready), 16'(2'b01 << (i % 2)));
            step();
            check($sformatf("fair_grant_id_%0d", i), 16'(grant_id), 16'(i % 2));
            step();
            check($sformatf("fair_rsp_valid_%0d", i), 16'(rsp_valid), 16'(2'b01 << (i % 2)));
            step();
        end
        req_valid = 2'b00;

        // Backpressure: owner 0 stalled 5 cycles, requester 1 waiting
        req_opcode0 = 3'b000; req_op1_0 = 12'h100; req_op2_0 = 12'h023;
        req_opcode1 = 3'b001; req_op1_1 = 12'hF0F; req_op2_1 = 12'h0FF;
        req_valid = 2'b11; rsp_ready = 2'b00;
        #1 check("bp_req_ready_acc", 16'(req_ready), 16'h1);
        step();
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_rsp_valid_%0d", i), 16'(rsp_valid), 16'h1);
            check($sformatf("bp_rsp_data_%0d", i),  16'(rsp_data),  16'h123);
            check($sformatf("bp_req_ready_%0d", i), 16'(req_ready), 16'h0);
            step();
        end
        rsp_ready = 2'b11;
        #1 check("bp_rsp_valid_release", 16'(rsp_valid), 16'h1);
        step();
        check("bp_rsp_valid_after", 16'(rsp_valid), 16'h0);
        check("bp_req_ready_r1",    16'(req_ready), 16'h2);
        step();
        req_valid = 2'b00;
        step();
        check("bp_r1_rsp_valid", 16'(rsp_valid), 16'h2);
        check("bp_r1_rsp_data",  16'(rsp_data),  16'h00F);
        step();

        // Reset mid-EXEC on the ALU_LAT=4 instance
        rst4 = 1'b0;
        step();
        req_valid4 = 2'b01; req_opcode0_4 = 3'b000; req_op1_0_4 = 12'h010; req_op2_0_4 = 12'h020;
        rsp_ready4 = 2'b11;
        #1 check("lat4_req_ready_a", 16'(req_ready4), 16'h1);
        step();
        req_valid4 = 2'b00;
        step();
        rst4 = 1'b1;
        #1 check("lat4_rsp_valid_exec2", 16'(rsp_valid4), 16'h0);
        step();
        rst4 = 1'b0;
        #1;
        check("lat4_abort_busy",      16'(busy4),      16'h0);
        check("lat4_abort_rsp_valid", 16'(rsp_valid4), 16'h0);
        check("lat4_abort_rsp_data",  16'(rsp_data4),  16'h0);
        check("lat4_abort_alu_op1",   16'(alu_op1_4),  16'h0);
        check("lat4_abort_grant_id",  16'(grant_id4),  16'h0);
        check("lat4_abort_req_ready", 16'(req_ready4), 16'h0);
        step();
        check("lat4_abort_no_late_rsp", 16'(rsp_valid4), 16'h0);

        // Following request completes after 5 cycles: 0x123 + 0x111 = 0x234
        req_valid4 = 2'b01; req_op1_0_4 = 12'h123; req_op2_0_4 = 12'h111;
        #1 check("lat4_req_ready_b", 16'(req_ready4), 16'h1);
        step();
        req_valid4 = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            #1 check($sformatf("lat4_exec_rsp_valid_%0d", k), 16'(rsp_valid4), 16'h0);
            step();
        end
        check("lat4_rsp_valid_c5", 16'(rsp_valid4), 16'h1);
        check("lat4_rsp_data_c5",  16'(rsp_data4),  16'h234);
        step();
        check("lat4_busy_done", 16'(busy4), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
